// File: rtl/tdm_demux_deser16.sv
`default_nettype none
// ============================================================================
// Module : tdm_demux_deser16
// Brief  : 1:16 TDM demultiplexer; rebuilds a slot-0-first serial frame into
//          a registered parallel word with a one-cycle valid strobe.
// Rev    : 1.0  initial release
// ============================================================================
module tdm_demux_deser16 #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [SEL_W-1:0] slot,
    output logic             frame_err
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] ONE       = SEL_W'(1);

    logic [0:0]       state;
    // The final slot bit goes straight to out_data, so the shadow holds one bit less.
    logic [WIDTH-2:0] shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= '0;
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (din_valid) begin
                case (state)
                    IDLE: begin
                        if (frame_start) begin
                            shadow[0] <= din;
                            slot      <= ONE;
                            state     <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (frame_start) begin
                            // Early frame_start: drop the partial frame, restart at slot 0.
                            frame_err <= 1'b1;
                            shadow[0] <= din;
                            slot      <= ONE;
                        end else if (slot == LAST_SLOT) begin
                            out_data  <= {din, shadow};
                            out_valid <= 1'b1;
                            slot      <= '0;
                            state     <= IDLE;
                        end else begin
                            shadow[slot] <= din;
                            slot         <= slot + ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        slot  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_deser16.sv
`default_nettype none
// ============================================================================
// Module : tb_tdm_demux_deser16
// Brief  : Directed, table-driven bench for tdm_demux_deser16.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tdm_demux_deser16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic [3:0]  slot;
    logic        frame_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    tdm_demux_deser16 #(.WIDTH(16), .SEL_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .slot        (slot),
        .frame_err   (frame_err)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        din;
        logic        dv;
        logic        fs;
        logic [15:0] e_data;
        logic        e_valid;
        logic [3:0]  e_slot;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void push(input string nm, input logic r, input logic d,
                                 input logic dv, input logic fs,
                                 input logic [15:0] ed, input logic ev,
                                 input logic [3:0] es, input logic ee);
        vec_t v;
        v.name = nm; v.rst = r; v.din = d; v.dv = dv; v.fs = fs;
        v.e_data = ed; v.e_valid = ev; v.e_slot = es; v.e_err = ee;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @vec%0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] word;

        // Test 1: reset, then 0xA5C3 with din_valid held high.
        push("t1_reset", 1, 0, 0, 0, 16'h0000, 0, 4'd0, 0);
        w = 16'hA5C3;
        for (int i = 0; i < 16; i++)
            push("t1_bit", 0, w[i], 1, (i == 0), (i == 15) ? w : 16'h0000,
                 (i == 15), 4'((i + 1) % 16), 0);
        push("t1_after", 0, 0, 0, 0, w, 0, 4'd0, 0);

        // Test 2: same word with a gap after every bit (frame_start in some gaps).
        push("t2_reset", 1, 0, 0, 0, 16'h0000, 0, 4'd0, 0);
        for (int i = 0; i < 16; i++) begin
            push("t2_bit", 0, w[i], 1, (i == 0), (i == 15) ? w : 16'h0000,
                 (i == 15), 4'((i + 1) % 16), 0);
            push("t2_gap", 0, ~w[i], 0, i[0], (i == 15) ? w : 16'h0000,
                 0, 4'((i + 1) % 16), 0);
        end

        // Test 3: back-to-back 0x1234 then 0xFFFF.
        w1 = 16'h1234;
        w2 = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            word = (i < 16) ? w1 : w2;
            push("t3_bit", 0, word[i % 16], 1, ((i % 16) == 0),
                 (i < 15) ? 16'hA5C3 : ((i < 31) ? w1 : w2),
                 (i == 15) || (i == 31), 4'((i + 1) % 16), 0);
        end
        push("t3_after", 0, 0, 0, 0, w2, 0, 4'd0, 0);

        // Test 4: abort at slot 7, then a full 0x00FF frame.
        w1 = 16'h0F0F;
        for (int i = 0; i < 7; i++)
            push("t4_part", 0, w1[i], 1, (i == 0), 16'hFFFF, 0, 4'(i + 1), 0);
        w = 16'h00FF;
        push("t4_abort", 0, w[0], 1, 1, 16'hFFFF, 0, 4'd1, 1);
        for (int i = 1; i < 16; i++)
            push("t4_bit", 0, w[i], 1, 0, (i == 15) ? w : 16'hFFFF,
                 (i == 15), 4'((i + 1) % 16), 0);
        push("t4_after", 0, 0, 0, 0, w, 0, 4'd0, 0);

        // Test 5: reset at slot 9, then 10 bits without frame_start.
        for (int i = 0; i < 9; i++)
            push("t5_part", 0, 1'b1, 1, (i == 0), 16'h00FF, 0, 4'(i + 1), 0);
        push("t5_reset", 1, 1, 1, 0, 16'h0000, 0, 4'd0, 0);
        for (int i = 0; i < 10; i++)
            push("t5_nostart", 0, 1'b1, 1, 0, 16'h0000, 0, 4'd0, 0);

        // Test 6: idle bits ignored, frame_start without din_valid ignored.
        for (int i = 0; i < 20; i++)
            push("t6_idle", 0, i[0], 1, 0, 16'h0000, 0, 4'd0, 0);
        push("t6_fs_nodv", 0, 1, 0, 1, 16'h0000, 0, 4'd0, 0);
        push("t6_hold", 0, 1, 1, 0, 16'h0000, 0, 4'd0, 0);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst         = vecs[k].rst;
            din         = vecs[k].din;
            din_valid   = vecs[k].dv;
            frame_start = vecs[k].fs;
            @(posedge clk);
            #1;
            chk({vecs[k].name, ".out_data"},  k, 32'(out_data),  32'(vecs[k].e_data));
            chk({vecs[k].name, ".out_valid"}, k, 32'(out_valid), 32'(vecs[k].e_valid));
            chk({vecs[k].name, ".slot"},      k, 32'(slot),      32'(vecs[k].e_slot));
            chk({vecs[k].name, ".frame_err"}, k, 32'(frame_err), 32'(vecs[k].e_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
